// File: rtl/ysyx_25010008_rd_arbiter_pkg.sv
// rtl/ysyx_25010008_rd_arbiter_pkg.sv - shared arbiter state/master encodings
// Purpose: encodings shared by the read arbiter and a future write arbiter.
// Contents: arbiter FSM states, master IDs, priority mode constants, helper.
package ysyx_25010008_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST_IFU = 1'b0,
        MST_LSU = 1'b1
    } master_e;

    localparam int unsigned PRIO_RR  = 0;
    localparam int unsigned PRIO_IFU = 1;
    localparam int unsigned PRIO_LSU = 2;

    function automatic master_e other_master(input master_e m);
        return (m == MST_IFU) ? MST_LSU : MST_IFU;
    endfunction

endpackage

// File: rtl/ysyx_25010008_rr_pick.sv
// rtl/ysyx_25010008_rr_pick.sv - 2-way round-robin / fixed-priority picker
// Purpose: choose one of IFU/LSU from their request lines.
// Ports:
//   ifu_req_i, lsu_req_i  request lines
//   last_grant_i          master that completed the previous transaction
//   valid_o               at least one request present
//   grant_o               selected master (meaningful when valid_o)
module ysyx_25010008_rr_pick
    import ysyx_25010008_rd_arbiter_pkg::*;
#(
    parameter int unsigned PRIORITY = PRIO_RR
) (
    input  logic    ifu_req_i,
    input  logic    lsu_req_i,
    input  master_e last_grant_i,
    output logic    valid_o,
    output master_e grant_o
);

    always_comb begin
        valid_o = ifu_req_i | lsu_req_i;
        grant_o = MST_IFU;
        if (ifu_req_i && lsu_req_i) begin
            if (PRIORITY == PRIO_IFU) begin
                grant_o = MST_IFU;
            end else if (PRIORITY == PRIO_LSU) begin
                grant_o = MST_LSU;
            end else begin
                // Round-robin: the master not served last wins the tie.
                grant_o = other_master(last_grant_i);
            end
        end else if (lsu_req_i) begin
            grant_o = MST_LSU;
        end
    end

endmodule

// File: rtl/ysyx_25010008_rd_arbiter.sv
// rtl/ysyx_25010008_rd_arbiter.sv - IFU/LSU read-channel arbiter, one outstanding read
// Purpose: serialise IFU and LSU AR/R handshakes onto one memory read port.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   ifu_* / lsu_*                master AR request/accept and R valid/ready
//   m_araddr, m_arvalid          registered request to memory
//   m_arready, m_rvalid          memory accept / response valid
//   m_rready                     ready of the owning master, forwarded
// Read data/response are wired from memory to both masters outside this block.
module ysyx_25010008_rd_arbiter
    import ysyx_25010008_rd_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned PRIORITY = PRIO_RR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic              m_rvalid,
    output logic              m_rready
);

    arb_state_e        state_q, state_d;
    master_e           owner_q, owner_d;
    master_e           last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              arvalid_q, arvalid_d;

    logic    pick_valid;
    master_e pick_id;
    logic    owner_rready;

    ysyx_25010008_rr_pick #(
        .PRIORITY (PRIORITY)
    ) u_pick (
        .ifu_req_i    (ifu_arvalid),
        .lsu_req_i    (lsu_arvalid),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .grant_o      (pick_id)
    );

    assign m_araddr  = addr_q;
    assign m_arvalid = arvalid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= MST_IFU;
            last_grant_q <= MST_LSU;
            addr_q       <= '0;
            arvalid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            arvalid_q    <= arvalid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        arvalid_d    = arvalid_q;
        ifu_arready  = 1'b0;
        lsu_arready  = 1'b0;
        ifu_rvalid   = 1'b0;
        lsu_rvalid   = 1'b0;
        m_rready     = 1'b0;
        owner_rready = (owner_q == MST_IFU) ? ifu_rready : lsu_rready;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d   = pick_id;
                    addr_d    = (pick_id == MST_IFU) ? ifu_araddr : lsu_araddr;
                    arvalid_d = 1'b1;
                    state_d   = ST_ADDR;
                    if (pick_id == MST_IFU) begin
                        ifu_arready = 1'b1;
                    end else begin
                        lsu_arready = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                m_rready = owner_rready;
                if (owner_q == MST_IFU) begin
                    ifu_rvalid = m_rvalid;
                end else begin
                    lsu_rvalid = m_rvalid;
                end
                // Returning to IDLE (not granting here) guarantees one idle
                // cycle between transactions.
                if (m_rvalid && owner_rready) begin
                    last_grant_d = owner_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_25010008_rd_arbiter.sv
// tb/tb_ysyx_25010008_rd_arbiter.sv - self-checking bench for the read arbiter
module tb_ysyx_25010008_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ifu_araddr, lsu_araddr;
    logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
    logic        m_arready, m_rvalid;

    logic        d0_ifu_arready, d0_ifu_rvalid, d0_lsu_arready, d0_lsu_rvalid;
    logic        d0_m_arvalid, d0_m_rready;
    logic [31:0] d0_m_araddr;
    logic        d2_ifu_arready, d2_ifu_rvalid, d2_lsu_arready, d2_lsu_rvalid;
    logic        d2_m_arvalid, d2_m_rready;
    logic [31:0] d2_m_araddr;

    bit          sel = 1'b0;
    logic [5:0]  obs;
    logic [31:0] obs_addr;

    always #5 clock = ~clock;

    ysyx_25010008_rd_arbiter #(.ADDR_W(32), .PRIORITY(0)) u_dut_rr (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(d0_ifu_arready),
        .ifu_rvalid(d0_ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(d0_lsu_arready),
        .lsu_rvalid(d0_lsu_rvalid), .lsu_rready(lsu_rready),
        .m_araddr(d0_m_araddr), .m_arvalid(d0_m_arvalid), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rready(d0_m_rready)
    );

    ysyx_25010008_rd_arbiter #(.ADDR_W(32), .PRIORITY(2)) u_dut_lsu (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(d2_ifu_arready),
        .ifu_rvalid(d2_ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(d2_lsu_arready),
        .lsu_rvalid(d2_lsu_rvalid), .lsu_rready(lsu_rready),
        .m_araddr(d2_m_araddr), .m_arvalid(d2_m_arvalid), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rready(d2_m_rready)
    );

    // Observed outputs of the DUT under test: {ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, m_arvalid, m_rready}
    assign obs = sel ? {d2_ifu_arready, d2_lsu_arready, d2_ifu_rvalid, d2_lsu_rvalid, d2_m_arvalid, d2_m_rready}
                     : {d0_ifu_arready, d0_lsu_arready, d0_ifu_rvalid, d0_lsu_rvalid, d0_m_arvalid, d0_m_rready};
    assign obs_addr = sel ? d2_m_araddr : d0_m_araddr;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level reference model
    bit          ifu_pend, lsu_pend;
    logic [31:0] ifu_req_addr, lsu_req_addr;
    bit          busy, addr_done;
    int          cur_owner, last_served;
    logic [31:0] cur_addr;
    int          grant_log[$];
    bit          tie_log[$];
    logic [31:0] addr_log[$];
    int          n_done;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        ifu_araddr = '0; lsu_araddr = '0;
        ifu_arvalid = 0; lsu_arvalid = 0;
        ifu_rready = 0; lsu_rready = 0;
        m_arready = 0; m_rvalid = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ifu_pend = 0; lsu_pend = 0;
        busy = 0; addr_done = 0; cur_owner = 0; last_served = 1;
        cur_addr = '0; n_done = 0;
        grant_log.delete(); tie_log.delete(); addr_log.delete();
    endtask

    // One cycle of random masters/memory plus full output comparison.
    task automatic model_cycle(input bit cont);
        bit tie, grant, in_resp, own_rr;
        int win;
        logic [5:0] exp_v;
        if (!ifu_pend && (cont || $urandom_range(99) < 35)) begin
            ifu_pend = 1; ifu_req_addr = $urandom & 32'hffff_fffc;
        end
        if (!lsu_pend && (cont || $urandom_range(99) < 35)) begin
            lsu_pend = 1; lsu_req_addr = $urandom & 32'hffff_fffc;
        end
        ifu_arvalid = ifu_pend;
        lsu_arvalid = lsu_pend;
        ifu_araddr  = ifu_pend ? ifu_req_addr : $urandom;
        lsu_araddr  = lsu_pend ? lsu_req_addr : $urandom;
        ifu_rready  = ($urandom_range(99) < 70);
        lsu_rready  = ($urandom_range(99) < 70);
        m_arready   = ($urandom_range(99) < 50);
        m_rvalid    = ($urandom_range(99) < 50);
        #2;
        tie = ifu_pend && lsu_pend;
        if (tie) begin
            if (sel) win = 1;                          // LSU-priority instance
            else     win = (last_served == 0) ? 1 : 0; // round-robin
        end else begin
            win = ifu_pend ? 0 : 1;
        end
        grant   = !busy && (ifu_pend || lsu_pend);
        in_resp = busy && addr_done;
        own_rr  = (cur_owner == 0) ? ifu_rready : lsu_rready;
        exp_v = {grant && win == 0, grant && win == 1,
                 in_resp && cur_owner == 0 && m_rvalid, in_resp && cur_owner == 1 && m_rvalid,
                 busy && !addr_done, in_resp && own_rr};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL random_outputs t=%0t got %b exp %b", $time, obs, exp_v);
        end
        if (busy && !addr_done) begin
            n_checks++;
            if (obs_addr !== cur_addr) begin
                n_errors++;
                $display("FAIL random_araddr t=%0t got %h exp %h", $time, obs_addr, cur_addr);
            end
        end
        if (grant) begin
            busy = 1; addr_done = 0; cur_owner = win;
            cur_addr = win ? lsu_req_addr : ifu_req_addr;
            if (win == 0) ifu_pend = 0; else lsu_pend = 0;
            grant_log.push_back(win); tie_log.push_back(tie); addr_log.push_back(cur_addr);
        end else if (busy && !addr_done) begin
            if (m_arready) addr_done = 1;
        end else if (in_resp && m_rvalid && own_rr) begin
            busy = 0; last_served = cur_owner; n_done++;
        end
        tick();
    endtask

    task automatic test_reset;
        sel = 0;
        do_reset();
        #2;
        n_checks++;
        if (obs !== 6'b0 || obs_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs got %b/%h exp 000000/00000000", obs, obs_addr);
        end
        tick();
    endtask

    task automatic test_single_ifu;
        sel = 0;
        do_reset();
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0000; ifu_rready = 1; lsu_rready = 1;
        #2;
        n_checks++;
        if (obs !== 6'b100000) begin n_errors++; $display("FAIL single_c0 got %b exp 100000", obs); end
        tick();
        ifu_arvalid = 0; m_arready = 1;
        #2;
        n_checks++;
        if (obs !== 6'b000010 || obs_addr !== 32'h3000_0000) begin
            n_errors++; $display("FAIL single_c1 got %b/%h exp 000010/30000000", obs, obs_addr);
        end
        tick();
        m_arready = 0;
        #2;
        n_checks++;
        if (obs !== 6'b000001) begin n_errors++; $display("FAIL single_c2 got %b exp 000001", obs); end
        tick();
        m_rvalid = 1;
        #2;
        n_checks++;
        if (obs !== 6'b001001) begin n_errors++; $display("FAIL single_c3 got %b exp 001001", obs); end
        tick();
        m_rvalid = 0;
        #2;
        n_checks++;
        if (obs !== 6'b000000) begin n_errors++; $display("FAIL single_c4 got %b exp 000000", obs); end
        tick();
    endtask

    task automatic test_tie_rr;
        int cyc = 0;
        sel = 0;
        do_reset();
        ifu_pend = 1; ifu_req_addr = 32'h3000_0004;
        lsu_pend = 1; lsu_req_addr = 32'h8000_0010;
        while (grant_log.size() < 3 && cyc < 300) begin model_cycle(1); cyc++; end
        n_checks++;
        if (grant_log.size() < 3) begin
            n_errors++; $display("FAIL tie_rr_timeout got %0d grants exp 3", grant_log.size());
        end else begin
            n_checks += 2;
            if (grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0) begin
                n_errors++;
                $display("FAIL tie_rr_order got %0d %0d %0d exp 0 1 0", grant_log[0], grant_log[1], grant_log[2]);
            end
            if (addr_log[0] !== 32'h3000_0004 || addr_log[1] !== 32'h8000_0010) begin
                n_errors++;
                $display("FAIL tie_rr_addr got %h %h exp 30000004 80000010", addr_log[0], addr_log[1]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc = 0;
        sel = 0;
        do_reset();
        while (grant_log.size() < 6 && cyc < 600) begin model_cycle(1); cyc++; end
        n_checks++;
        if (grant_log.size() < 6) begin
            n_errors++; $display("FAIL b2b_timeout got %0d grants exp 6", grant_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (grant_log[i] != (i % 2)) begin
                    n_errors++; $display("FAIL b2b_alternate idx %0d got %0d exp %0d", i, grant_log[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_lsu_priority;
        int cyc = 0;
        sel = 1;
        do_reset();
        while (grant_log.size() < 5 && cyc < 500) begin model_cycle(1); cyc++; end
        n_checks++;
        if (grant_log.size() < 5) begin
            n_errors++; $display("FAIL prio_timeout got %0d grants exp 5", grant_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (tie_log[i] && grant_log[i] != 1) begin
                    n_errors++; $display("FAIL prio_lsu_tie idx %0d got %0d exp 1", i, grant_log[i]);
                end
            end
        end
        for (int i = 0; i < 200; i++) model_cycle(0);
        sel = 0;
    endtask

    task automatic test_random;
        sel = 0;
        do_reset();
        for (int i = 0; i < 400; i++) model_cycle(0);
        n_checks++;
        if (n_done < 10) begin
            n_errors++; $display("FAIL random_progress got %0d completions exp >= 10", n_done);
        end
    endtask

    task automatic test_rready_stall;
        sel = 0;
        do_reset();
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0040; lsu_rready = 1;
        tick();
        ifu_arvalid = 0; m_arready = 1;
        tick();
        m_arready = 0; m_rvalid = 1; ifu_rready = 0;
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0020;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++;
            if (obs !== 6'b001000) begin n_errors++; $display("FAIL stall_hold cyc %0d got %b exp 001000", i, obs); end
            tick();
        end
        ifu_rready = 1;
        #2;
        n_checks++;
        if (obs !== 6'b001001) begin n_errors++; $display("FAIL stall_release got %b exp 001001", obs); end
        tick();
        m_rvalid = 0;
        #2;
        n_checks++;
        if (obs !== 6'b010000) begin n_errors++; $display("FAIL stall_next_grant got %b exp 010000", obs); end
        tick();
        lsu_arvalid = 0;
    endtask

    task automatic test_reset_mid;
        sel = 0;
        do_reset();
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0080; ifu_rready = 1;
        tick();
        ifu_arvalid = 0; m_arready = 1;
        tick();
        m_arready = 0;
        reset = 1;
        tick();
        reset = 0; m_rvalid = 0; ifu_rready = 1; lsu_rready = 1;
        #2;
        n_checks++;
        if (obs !== 6'b0 || obs_addr !== 32'h0) begin
            n_errors++; $display("FAIL midreset_clear got %b/%h exp 000000/00000000", obs, obs_addr);
        end
        tick();
        m_rvalid = 1;
        #2;
        n_checks++;
        if (obs !== 6'b0) begin n_errors++; $display("FAIL stray_idle got %b exp 000000", obs); end
        tick();
        m_rvalid = 0; lsu_arvalid = 1; lsu_araddr = 32'h8000_0100;
        #2;
        n_checks++;
        if (obs !== 6'b010000) begin n_errors++; $display("FAIL midreset_lsu_grant got %b exp 010000", obs); end
        tick();
        lsu_arvalid = 0; m_rvalid = 1;
        #2;
        n_checks++;
        if (obs !== 6'b000010 || obs_addr !== 32'h8000_0100) begin
            n_errors++; $display("FAIL stray_addr got %b/%h exp 000010/80000100", obs, obs_addr);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        test_reset();
        test_single_ifu();
        test_tie_rr();
        test_back_to_back();
        test_lsu_priority();
        test_rready_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
